// File: rtl/shared_ram_arbiter.sv
// shared_ram_arbiter
//   Local block-RAM window shared by N requesters. Any access whose address
//   falls inside [WIN_BASE, WIN_BASE+WIN_SIZE) is served here. Everything else
//   is ignored and left to the SDRAM path. One access is granted per cycle,
//   either by fixed priority (lowest index) or by round-robin. An override
//   input gives OVERRIDE_PORT absolute priority. Ack and read data are
//   registered, so they appear one cycle after the grant.
//
// Ports
//   i_clk        single clock
//   i_reset      synchronous, active-high reset
//   i_req        per-port request level, held until o_ack
//   i_we         per-port 1 = write, 0 = read
//   i_addr       per-port address, port p at [p*ADDR_W +: ADDR_W]
//   i_wdata      per-port write data, port p at [p*DATA_W +: DATA_W]
//   i_override   OVERRIDE_PORT wins whenever it is eligible
//   o_hit        combinational: request present and address inside window
//   o_ack        one-cycle pulse, access completed
//   o_rvalid     one-cycle pulse alongside o_ack for reads
//   o_rdata      read data, holds its value between reads
//   o_busy       any window traffic pending (|o_hit)
//   o_conflicts  saturating count of cycles with more than one eligible port
module shared_ram_arbiter #(
    parameter int N_PORTS       = 2,
    parameter int ADDR_W        = 22,
    parameter int DATA_W        = 8,
    parameter int WIN_BASE      = 'h6000,
    parameter int WIN_SIZE      = 8192,
    parameter int PRIO_MODE     = 0,
    parameter int OVERRIDE_PORT = 1
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [N_PORTS-1:0]        i_req,
    input  logic [N_PORTS-1:0]        i_we,
    input  logic [N_PORTS*ADDR_W-1:0] i_addr,
    input  logic [N_PORTS*DATA_W-1:0] i_wdata,
    input  logic                      i_override,
    output logic [N_PORTS-1:0]        o_hit,
    output logic [N_PORTS-1:0]        o_ack,
    output logic [N_PORTS-1:0]        o_rvalid,
    output logic [DATA_W-1:0]         o_rdata,
    output logic                      o_busy,
    output logic [15:0]               o_conflicts
);
    localparam int IDX_W = $clog2(WIN_SIZE);
    localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam logic [ADDR_W-1:0]       BASE_A   = ADDR_W'(WIN_BASE);
    // WIN_BASE is aligned to WIN_SIZE, so the window test reduces to
    // matching the address bits above the RAM index.
    localparam logic [ADDR_W-IDX_W-1:0] BASE_TAG = BASE_A[ADDR_W-1:IDX_W];

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [DATA_W-1:0]  mem [WIN_SIZE];

    logic [N_PORTS-1:0] hit_p0;
    logic [N_PORTS-1:0] elig_p0;
    logic [N_PORTS-1:0] gnt_oh_p0;
    logic [PTR_W-1:0]   gnt_idx_p0;
    logic [PTR_W-1:0]   cand_p0;
    logic               gnt_vld_p0;
    logic               gnt_we_p0;
    logic               multi_p0;
    logic [ADDR_W-1:0]  gnt_addr_p0;
    logic [DATA_W-1:0]  gnt_wdata_p0;
    logic [IDX_W-1:0]   ram_idx_p0;

    logic [N_PORTS-1:0] ack_p1;
    logic [N_PORTS-1:0] rvalid_p1;
    logic [DATA_W-1:0]  rdata_p1;
    logic [PTR_W-1:0]   rr_ptr;
    logic [15:0]        conflicts;

    // ---- stage p0: window decode, eligibility, grant selection ----
    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            hit_p0[p] = i_req[p] && (i_addr[p*ADDR_W+IDX_W +: ADDR_W-IDX_W] == BASE_TAG);
        end
    end

    // ack_p1 is exactly last cycle's grant, so it doubles as the winner mask
    // that keeps a still-held request from being served twice.
    assign elig_p0  = hit_p0 & ~ack_p1;
    // x & (x-1) clears the lowest set bit; anything left means >1 eligible.
    assign multi_p0 = |(elig_p0 & (elig_p0 - N_PORTS'(1)));

    always_comb begin
        gnt_vld_p0 = 1'b0;
        gnt_idx_p0 = '0;
        cand_p0    = '0;
        if (i_override && elig_p0[OVERRIDE_PORT]) begin
            gnt_vld_p0 = 1'b1;
            gnt_idx_p0 = PTR_W'(OVERRIDE_PORT);
        end else if (PRIO_MODE == 0) begin
            // Scan downwards so the lowest eligible index is assigned last.
            for (int p = N_PORTS - 1; p >= 0; p--) begin
                if (elig_p0[p]) begin
                    gnt_vld_p0 = 1'b1;
                    gnt_idx_p0 = PTR_W'(p);
                end
            end
        end else begin
            // Same trick: offset 1 from rr_ptr is visited last and wins.
            for (int k = N_PORTS; k >= 1; k--) begin
                cand_p0 = PTR_W'((int'(rr_ptr) + k) % N_PORTS);
                if (elig_p0[cand_p0]) begin
                    gnt_vld_p0 = 1'b1;
                    gnt_idx_p0 = cand_p0;
                end
            end
        end
    end

    always_comb begin
        gnt_oh_p0    = '0;
        gnt_we_p0    = 1'b0;
        gnt_addr_p0  = '0;
        gnt_wdata_p0 = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (gnt_vld_p0 && gnt_idx_p0 == PTR_W'(p)) begin
                gnt_oh_p0[p] = 1'b1;
                gnt_we_p0    = i_we[p];
                gnt_addr_p0  = i_addr[p*ADDR_W +: ADDR_W];
                gnt_wdata_p0 = i_wdata[p*DATA_W +: DATA_W];
            end
        end
        ram_idx_p0 = IDX_W'(gnt_addr_p0 - BASE_A);
    end

    // ---- stage p1: RAM access, registered ack / read data ----
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ack_p1    <= '0;
            rvalid_p1 <= '0;
            rdata_p1  <= '0;
            rr_ptr    <= PTR_W'(N_PORTS - 1);
            conflicts <= '0;
        end else begin
            ack_p1    <= gnt_oh_p0;
            rvalid_p1 <= gnt_we_p0 ? '0 : gnt_oh_p0;
            if (gnt_vld_p0) begin
                rr_ptr <= gnt_idx_p0;
                if (!gnt_we_p0) begin
                    rdata_p1 <= mem[ram_idx_p0];
                end
            end
            if (multi_p0) begin
                conflicts <= sat_inc16(conflicts);
            end
        end
    end

    // RAM contents survive reset, but nothing is written during a reset cycle.
    always_ff @(posedge i_clk) begin
        if (!i_reset && gnt_vld_p0 && gnt_we_p0) begin
            mem[ram_idx_p0] <= gnt_wdata_p0;
        end
    end

    assign o_hit       = hit_p0;
    assign o_busy      = |hit_p0;
    assign o_ack       = ack_p1;
    assign o_rvalid    = rvalid_p1;
    assign o_rdata     = rdata_p1;
    assign o_conflicts = conflicts;

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// tb_shared_ram_arbiter
//   Two instances: dut0 (2 ports, fixed priority, override port 1) and
//   dut1 (4 ports, round-robin, override port 2). Directed scenarios plus a
//   randomized run against a cycle-level reference model of the arbitration
//   rules, window decode, RAM and conflict counter.
module tb_shared_ram_arbiter;
    localparam int AW = 22;
    localparam int DW = 8;
    localparam int WB = 'h6000;
    localparam int WS = 8192;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          rq [2][4];
    logic          wr [2][4];
    logic [AW-1:0] ad [2][4];
    logic [DW-1:0] wd [2][4];
    logic          ov [2];

    logic [1:0]      req0, we0, hit0, ack0, rvalid0;
    logic [2*AW-1:0] addr0;
    logic [2*DW-1:0] wdata0;
    logic [DW-1:0]   rdata0;
    logic            busy0;
    logic [15:0]     conf0;

    logic [3:0]      req1, we1, hit1, ack1, rvalid1;
    logic [4*AW-1:0] addr1;
    logic [4*DW-1:0] wdata1;
    logic [DW-1:0]   rdata1;
    logic            busy1;
    logic [15:0]     conf1;

    logic [3:0]  a_hit [2];
    logic [3:0]  a_ack [2];
    logic [3:0]  a_rv  [2];
    logic [7:0]  a_rd  [2];
    logic        a_busy[2];
    logic [15:0] a_conf[2];

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            req0[p] = rq[0][p];
            we0[p]  = wr[0][p];
            addr0[p*AW +: AW]  = ad[0][p];
            wdata0[p*DW +: DW] = wd[0][p];
        end
        for (int p = 0; p < 4; p++) begin
            req1[p] = rq[1][p];
            we1[p]  = wr[1][p];
            addr1[p*AW +: AW]  = ad[1][p];
            wdata1[p*DW +: DW] = wd[1][p];
        end
    end

    assign a_hit[0]  = {2'b00, hit0};
    assign a_ack[0]  = {2'b00, ack0};
    assign a_rv[0]   = {2'b00, rvalid0};
    assign a_rd[0]   = rdata0;
    assign a_busy[0] = busy0;
    assign a_conf[0] = conf0;
    assign a_hit[1]  = hit1;
    assign a_ack[1]  = ack1;
    assign a_rv[1]   = rvalid1;
    assign a_rd[1]   = rdata1;
    assign a_busy[1] = busy1;
    assign a_conf[1] = conf1;

    shared_ram_arbiter #(.N_PORTS(2), .ADDR_W(AW), .DATA_W(DW), .WIN_BASE(WB), .WIN_SIZE(WS),
                         .PRIO_MODE(0), .OVERRIDE_PORT(1)) dut0 (
        .i_clk(clk), .i_reset(rst), .i_req(req0), .i_we(we0), .i_addr(addr0),
        .i_wdata(wdata0), .i_override(ov[0]), .o_hit(hit0), .o_ack(ack0),
        .o_rvalid(rvalid0), .o_rdata(rdata0), .o_busy(busy0), .o_conflicts(conf0));

    shared_ram_arbiter #(.N_PORTS(4), .ADDR_W(AW), .DATA_W(DW), .WIN_BASE(WB), .WIN_SIZE(WS),
                         .PRIO_MODE(1), .OVERRIDE_PORT(2)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_req(req1), .i_we(we1), .i_addr(addr1),
        .i_wdata(wdata1), .i_override(ov[1]), .o_hit(hit1), .o_ack(ack1),
        .o_rvalid(rvalid1), .o_rdata(rdata1), .o_busy(busy1), .o_conflicts(conf1));

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    logic [7:0] m_mem   [2][WS];
    bit         m_known [2][WS];
    int         m_last  [2];
    int         m_rr    [2];
    int         m_conf  [2];
    int         g_pend  [2];
    int         c_pend  [2];
    logic [3:0] e_hit   [2];
    logic [3:0] e_ack   [2];
    logic [3:0] e_rv    [2];
    logic [7:0] e_rd    [2];
    bit         e_rknown[2];

    function automatic int nports(input int d);
        return (d == 0) ? 2 : 4;
    endfunction

    function automatic bit in_win(input logic [AW-1:0] a);
        return (int'(a) >= WB) && (int'(a) < WB + WS);
    endfunction

    // Decide this cycle's winner from the current inputs and model state.
    task automatic model_comb();
        for (int d = 0; d < 2; d++) begin
            int n;
            int ovp;
            int cnt;
            int g;
            bit elig[4];
            int order[$];
            n   = nports(d);
            ovp = (d == 0) ? 1 : 2;
            cnt = 0;
            g   = -1;
            e_hit[d] = 4'b0000;
            order.delete();
            for (int p = 0; p < 4; p++) elig[p] = 1'b0;
            for (int p = 0; p < n; p++) begin
                e_hit[d][p] = rq[d][p] && in_win(ad[d][p]);
                elig[p] = e_hit[d][p] && (p != m_last[d]);
                if (elig[p]) cnt++;
            end
            if (ov[d] && elig[ovp]) begin
                g = ovp;
            end else begin
                for (int k = 0; k < n; k++)
                    order.push_back((d == 0) ? k : (m_rr[d] + 1 + k) % n);
                foreach (order[i]) if (g < 0 && elig[order[i]]) g = order[i];
            end
            g_pend[d] = g;
            c_pend[d] = cnt;
        end
    endtask

    // Apply the clock edge to the model and form the expected registered outputs.
    task automatic model_seq();
        for (int d = 0; d < 2; d++) begin
            int g;
            int idx;
            if (rst) begin
                e_ack[d] = 4'b0; e_rv[d] = 4'b0; e_rd[d] = 8'h00; e_rknown[d] = 1'b1;
                m_conf[d] = 0; m_rr[d] = nports(d) - 1; m_last[d] = -1;
            end else begin
                e_ack[d] = 4'b0; e_rv[d] = 4'b0;
                if (c_pend[d] > 1 && m_conf[d] < 65535) m_conf[d]++;
                g = g_pend[d];
                if (g >= 0) begin
                    idx = int'(ad[d][g]) - WB;
                    e_ack[d][g] = 1'b1;
                    if (wr[d][g]) begin
                        m_mem[d][idx] = wd[d][g];
                        m_known[d][idx] = 1'b1;
                    end else begin
                        e_rv[d][g] = 1'b1;
                        e_rd[d] = m_mem[d][idx];
                        e_rknown[d] = m_known[d][idx];
                    end
                    m_rr[d] = g;
                end
                m_last[d] = g;
            end
        end
    endtask

    task automatic tick();
        model_comb();
        @(posedge clk);
        model_seq();
        #1;
    endtask

    task automatic settle();
        #1;
        model_comb();
    endtask

    task automatic clear_inputs();
        for (int d = 0; d < 2; d++) begin
            ov[d] = 1'b0;
            for (int p = 0; p < 4; p++) begin
                rq[d][p] = 1'b0; wr[d][p] = 1'b0; ad[d][p] = '0; wd[d][p] = '0;
            end
        end
    endtask

    // Drive one request until acked (bounded), then drop it for one idle cycle.
    task automatic access(input int d, input int p, input bit w, input int addr,
                          input logic [7:0] data, output int lat,
                          output logic [7:0] rd, output logic rv);
        int i;
        rq[d][p] = 1'b1; wr[d][p] = w; ad[d][p] = AW'(addr); wd[d][p] = data;
        lat = -1; rd = '0; rv = 1'b0; i = 0;
        while (lat < 0 && i < 20) begin
            i++;
            tick();
            if (a_ack[d][p]) begin
                lat = i; rd = a_rd[d]; rv = a_rv[d][p];
            end
        end
        rq[d][p] = 1'b0;
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            checks++; if (a_ack[d] !== 4'b0) begin errors++; $display("FAIL reset_ack d%0d: got %b expected 0", d, a_ack[d]); end
            checks++; if (a_rv[d] !== 4'b0) begin errors++; $display("FAIL reset_rvalid d%0d: got %b expected 0", d, a_rv[d]); end
            checks++; if (a_rd[d] !== 8'h00) begin errors++; $display("FAIL reset_rdata d%0d: got %h expected 00", d, a_rd[d]); end
            checks++; if (a_conf[d] !== 16'h0) begin errors++; $display("FAIL reset_conf d%0d: got %0d expected 0", d, a_conf[d]); end
        end
        rst = 1'b0;
    endtask

    task automatic test_single_port();
        rq[0][0] = 1'b1; wr[0][0] = 1'b1; ad[0][0] = AW'('h6010); wd[0][0] = 8'hA5;
        settle();
        checks++; if (hit0 !== 2'b01) begin errors++; $display("FAIL single_hit: got %b expected 01", hit0); end
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy0); end
        tick();
        checks++; if (ack0 !== 2'b01) begin errors++; $display("FAIL single_wr_ack: got %b expected 01", ack0); end
        checks++; if (rvalid0 !== 2'b00) begin errors++; $display("FAIL single_wr_rvalid: got %b expected 00", rvalid0); end
        wr[0][0] = 1'b0;
        tick();
        checks++; if (ack0 !== 2'b00) begin errors++; $display("FAIL single_masked: got %b expected 00", ack0); end
        tick();
        checks++; if (ack0 !== 2'b01) begin errors++; $display("FAIL single_rd_ack: got %b expected 01", ack0); end
        checks++; if (rvalid0 !== 2'b01) begin errors++; $display("FAIL single_rd_rvalid: got %b expected 01", rvalid0); end
        checks++; if (rdata0 !== 8'hA5) begin errors++; $display("FAIL single_rdata: got %h expected a5", rdata0); end
        rq[0][0] = 1'b0;
        tick();
        checks++; if (rvalid0 !== 2'b00) begin errors++; $display("FAIL single_rvalid_drop: got %b expected 00", rvalid0); end
        checks++; if (rdata0 !== 8'hA5) begin errors++; $display("FAIL single_rdata_hold: got %h expected a5", rdata0); end
    endtask

    task automatic test_boundaries();
        int outside[2] = '{'h5FFF, 'h8000};
        int lat;
        logic [7:0] rd;
        logic rv;
        foreach (outside[i]) begin
            rq[0][0] = 1'b1; wr[0][0] = 1'b0; ad[0][0] = AW'(outside[i]);
            settle();
            checks++; if (hit0 !== 2'b00) begin errors++; $display("FAIL bound_hit %h: got %b expected 00", outside[i], hit0); end
            checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL bound_busy %h: got %b expected 0", outside[i], busy0); end
            for (int c = 0; c < 3; c++) begin
                tick();
                checks++; if (ack0 !== 2'b00) begin errors++; $display("FAIL bound_ack %h: got %b expected 00", outside[i], ack0); end
            end
        end
        rq[0][0] = 1'b0;
        tick();
        access(0, 0, 1'b1, 'h6000, 8'h5A, lat, rd, rv);
        checks++; if (lat !== 1) begin errors++; $display("FAIL bound_wr_lo_lat: got %0d expected 1", lat); end
        access(0, 0, 1'b1, 'h7FFF, 8'hC3, lat, rd, rv);
        checks++; if (lat !== 1) begin errors++; $display("FAIL bound_wr_hi_lat: got %0d expected 1", lat); end
        checks++; if (rv !== 1'b0) begin errors++; $display("FAIL bound_wr_rvalid: got %b expected 0", rv); end
        access(0, 0, 1'b0, 'h6000, 8'h00, lat, rd, rv);
        checks++; if (rd !== 8'h5A || rv !== 1'b1) begin errors++; $display("FAIL bound_rd_lo: got %h/%b expected 5a/1", rd, rv); end
        access(0, 0, 1'b0, 'h7FFF, 8'h00, lat, rd, rv);
        checks++; if (rd !== 8'hC3 || lat !== 1) begin errors++; $display("FAIL bound_rd_hi: got %h lat %0d expected c3 lat 1", rd, lat); end
    endtask

    task automatic test_fixed_alternate();
        logic [1:0] exp_ack[4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [7:0] exp_rd[4]  = '{8'hA5, 8'h5A, 8'hA5, 8'h5A};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rq[0][0] = 1'b1; wr[0][0] = 1'b0; ad[0][0] = AW'('h6010);
        rq[0][1] = 1'b1; wr[0][1] = 1'b0; ad[0][1] = AW'('h6000);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (ack0 !== exp_ack[i]) begin errors++; $display("FAIL alt_ack[%0d]: got %b expected %b", i, ack0, exp_ack[i]); end
            checks++; if (rdata0 !== exp_rd[i]) begin errors++; $display("FAIL alt_rdata[%0d]: got %h expected %h", i, rdata0, exp_rd[i]); end
        end
        checks++; if (conf0 !== 16'd1) begin errors++; $display("FAIL alt_conflicts: got %0d expected 1", conf0); end
        rq[0][0] = 1'b0; rq[0][1] = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        int last_g[4] = '{-1, -1, -1, -1};
        int maxgap[4] = '{0, 0, 0, 0};
        logic [3:0] exp;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int p = 0; p < 4; p++) begin
            rq[1][p] = 1'b1; wr[1][p] = 1'b0; ad[1][p] = AW'(WB + 'h100 + p);
        end
        for (int i = 0; i < 13; i++) begin
            tick();
            exp = 4'b0001 << (i % 4);
            if (i < 5) begin
                checks++; if (ack1 !== exp) begin errors++; $display("FAIL rr_ack[%0d]: got %b expected %b", i, ack1, exp); end
            end
            if (i == 4) begin
                checks++; if (conf1 !== 16'd5) begin errors++; $display("FAIL rr_conflicts: got %0d expected 5", conf1); end
            end
            for (int p = 0; p < 4; p++) begin
                if (ack1[p]) begin
                    if (i - last_g[p] > maxgap[p]) maxgap[p] = i - last_g[p];
                    last_g[p] = i;
                end
            end
        end
        for (int p = 0; p < 4; p++) begin
            if (12 - last_g[p] > maxgap[p]) maxgap[p] = 12 - last_g[p];
            checks++; if (maxgap[p] > 4) begin errors++; $display("FAIL rr_wait port%0d: got %0d cycles expected <= 4", p, maxgap[p]); end
        end
        for (int p = 0; p < 4; p++) rq[1][p] = 1'b0;
        tick();
    endtask

    task automatic test_override();
        int lat;
        logic [7:0] rd;
        logic rv;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ov[0] = 1'b1;
        rq[0][0] = 1'b1; wr[0][0] = 1'b1; ad[0][0] = AW'('h6020); wd[0][0] = 8'h77;
        rq[0][1] = 1'b1; wr[0][1] = 1'b1; ad[0][1] = AW'('h6020); wd[0][1] = 8'h99;
        tick();
        checks++; if (ack0 !== 2'b10) begin errors++; $display("FAIL ovr_first: got %b expected 10", ack0); end
        rq[0][1] = 1'b0;
        tick();
        checks++; if (ack0 !== 2'b01) begin errors++; $display("FAIL ovr_second: got %b expected 01", ack0); end
        checks++; if (conf0 !== 16'd1) begin errors++; $display("FAIL ovr_conflicts: got %0d expected 1", conf0); end
        rq[0][0] = 1'b0; ov[0] = 1'b0;
        tick();
        access(0, 1, 1'b0, 'h6020, 8'h00, lat, rd, rv);
        checks++; if (rd !== 8'h77 || lat !== 1) begin errors++; $display("FAIL ovr_readback: got %h lat %0d expected 77 lat 1", rd, lat); end
    endtask

    task automatic test_reset_mid_write();
        int lat;
        logic [7:0] rd;
        logic rv;
        access(0, 0, 1'b1, 'h6030, 8'h11, lat, rd, rv);
        checks++; if (lat !== 1) begin errors++; $display("FAIL rstw_pre_lat: got %0d expected 1", lat); end
        rq[0][0] = 1'b1; wr[0][0] = 1'b1; ad[0][0] = AW'('h6030); wd[0][0] = 8'h3C;
        rst = 1'b1;
        tick();
        checks++; if (ack0 !== 2'b00) begin errors++; $display("FAIL rstw_ack: got %b expected 00", ack0); end
        checks++; if (rvalid0 !== 2'b00 || rdata0 !== 8'h00 || conf0 !== 16'd0) begin
            errors++; $display("FAIL rstw_outputs: got rv %b rd %h conf %0d expected 00/00/0", rvalid0, rdata0, conf0);
        end
        rq[0][0] = 1'b0; rst = 1'b0;
        tick();
        access(0, 0, 1'b0, 'h6030, 8'h00, lat, rd, rv);
        checks++; if (rd !== 8'h11) begin errors++; $display("FAIL rstw_ram: got %h expected 11", rd); end
    endtask

    task automatic test_random();
        clear_inputs();
        rst = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < nports(d); p++) begin
                    if (!(rq[d][p] && in_win(ad[d][p])) || a_ack[d][p]) begin
                        rq[d][p] = ($urandom_range(0, 4) != 0);
                        wr[d][p] = 1'($urandom_range(0, 1));
                        case ($urandom_range(0, 9))
                            0: ad[d][p] = AW'('h5FFF);
                            1: ad[d][p] = AW'('h8000);
                            2: ad[d][p] = AW'($urandom);
                            default: ad[d][p] = AW'(($urandom_range(0, 1) ? 'h6000 : 'h7FF8) + $urandom_range(0, 7));
                        endcase
                        wd[d][p] = 8'($urandom);
                    end
                end
                ov[d] = ($urandom_range(0, 3) == 0);
            end
            rst = ($urandom_range(0, 299) == 0);
            settle();
            for (int d = 0; d < 2; d++) begin
                checks++; if (a_hit[d] !== e_hit[d]) begin errors++; $display("FAIL rnd_hit d%0d c%0d: got %b expected %b", d, cyc, a_hit[d], e_hit[d]); end
                checks++; if (a_busy[d] !== (e_hit[d] != 4'b0)) begin errors++; $display("FAIL rnd_busy d%0d c%0d: got %b", d, cyc, a_busy[d]); end
            end
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++; if (a_ack[d] !== e_ack[d]) begin errors++; $display("FAIL rnd_ack d%0d c%0d: got %b expected %b", d, cyc, a_ack[d], e_ack[d]); end
                checks++; if (a_rv[d] !== e_rv[d]) begin errors++; $display("FAIL rnd_rvalid d%0d c%0d: got %b expected %b", d, cyc, a_rv[d], e_rv[d]); end
                checks++; if (a_conf[d] !== 16'(m_conf[d])) begin errors++; $display("FAIL rnd_conf d%0d c%0d: got %0d expected %0d", d, cyc, a_conf[d], m_conf[d]); end
                if (e_rknown[d]) begin
                    checks++; if (a_rd[d] !== e_rd[d]) begin errors++; $display("FAIL rnd_rdata d%0d c%0d: got %h expected %h", d, cyc, a_rd[d], e_rd[d]); end
                end
            end
        end
        clear_inputs();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_last[d] = -1; m_rr[d] = nports(d) - 1; m_conf[d] = 0;
            e_rknown[d] = 1'b0; e_rd[d] = '0;
        end
        test_reset();
        test_single_port();
        test_boundaries();
        test_fixed_alternate();
        test_round_robin();
        test_override();
        test_reset_mid_write();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
